// File: rtl/ioctl_loader_bridge_if.sv
// Signal bundle between the hps_io ioctl download port and the PC88 core
// loader port, plus the bridge's status outputs.
// master = the surrounding environment (hps_io + core), slave = the bridge.
interface ioctl_loader_bridge_if #(
  parameter int ADDR_W = 19
);
  // ioctl download side
  logic              dl_active;
  logic              dl_wr;
  logic [ADDR_W-1:0] dl_addr;
  logic [7:0]        dl_data;
  logic              dl_wait;

  // loader side
  logic [ADDR_W-1:0] ldr_adr;
  logic [7:0]        ldr_wdat;
  logic              ldr_wr;
  logic              ldr_ack;
  logic              ldr_oe;
  logic              ldr_done;

  // status
  logic [ADDR_W:0]   byte_count;
  logic              err_ovf;
  logic              err_timeout;

  modport master (
    output dl_active, dl_wr, dl_addr, dl_data, ldr_ack,
    input  dl_wait, ldr_adr, ldr_wdat, ldr_wr, ldr_oe, ldr_done,
           byte_count, err_ovf, err_timeout
  );

  modport slave (
    input  dl_active, dl_wr, dl_addr, dl_data, ldr_ack,
    output dl_wait, ldr_adr, ldr_wdat, ldr_wr, ldr_oe, ldr_done,
           byte_count, err_ovf, err_timeout
  );
endinterface

// File: rtl/ioctl_loader_bridge.sv
// Buffers the HPS ioctl ROM/IPL download stream in a small FIFO and replays
// it into the PC88 loader port under a request/acknowledge handshake, with
// ioctl back-pressure, ack timeout and sticky completion tracking.
// ADDR_W must match the ADDR_W of the connected interface instance.
module ioctl_loader_bridge #(
  parameter int ADDR_W      = 19,
  parameter int DEPTH_LOG2  = 2,
  parameter int ACK_TIMEOUT = 4095
) (
  input  logic                   clk21m,
  input  logic                   rstn,
  ioctl_loader_bridge_if.slave   bus
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CNT_W = DEPTH_LOG2 + 1;
  localparam int ENT_W = ADDR_W + 8;
  localparam int TMO_W = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);

  // Output handshake FSM encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_REL  = 2'd2;

  // FIFO storage and bookkeeping
  logic [ENT_W-1:0]      r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  logic                  r_dl_wait;
  logic                  r_err_ovf;

  // Edge detection and completion
  logic                  r_ack_q;
  logic                  r_dl_active_q;
  logic                  r_pend_end;
  logic                  r_ldr_done;
  logic                  r_ldr_oe;

  // Output FSM and loader-side registers
  logic [1:0]            r_state;
  logic                  r_ldr_wr;
  logic [ADDR_W-1:0]     r_ldr_adr;
  logic [7:0]            r_ldr_wdat;
  logic [TMO_W-1:0]      r_tcnt;
  logic [ADDR_W:0]       r_byte_count;
  logic                  r_err_timeout;

  logic                  w_full;
  logic                  w_fifo_empty;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_issue;
  logic                  w_ack_rise;
  logic                  w_tmo_hit;
  logic                  w_dl_fall;
  logic [CNT_W-1:0]      w_count_next;
  logic [ENT_W-1:0]      w_head;

  // The full check deliberately ignores a same-cycle pop: a byte arriving
  // while the FIFO is full is dropped even if the head is leaving.
  assign w_full       = (r_count == CNT_W'(DEPTH));
  assign w_fifo_empty = (r_count == '0);
  assign w_push       = bus.dl_wr & ~r_ldr_done & ~w_full;
  assign w_ack_rise   = bus.ldr_ack & ~r_ack_q;
  assign w_tmo_hit    = (r_tcnt == TMO_W'(ACK_TIMEOUT));
  assign w_pop        = (r_state == ST_REQ) & (w_ack_rise | w_tmo_hit);
  assign w_issue      = (r_state == ST_IDLE) & ~w_fifo_empty;
  assign w_dl_fall    = r_dl_active_q & ~bus.dl_active;
  assign w_count_next = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
  assign w_head       = r_mem[r_rd_ptr];

  // FIFO entry storage, written on every accepted byte
  // NOTE: the storage array has no reset; validity is tracked entirely by
  // r_count and the pointers, so stale contents are never observed.
  always_ff @(posedge clk21m) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {bus.dl_addr, bus.dl_data};
    end
  end

  // FIFO pointers, occupancy, back-pressure and overflow flag
  // NOTE: all state is updated with non-blocking assignments so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk21m or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_dl_wait <= 1'b0;
      r_err_ovf <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + DEPTH_LOG2'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + DEPTH_LOG2'(1);
      end
      r_count <= w_count_next;
      // Raised one slot early so the HPS has a cycle to react before full
      r_dl_wait <= (w_count_next >= CNT_W'(DEPTH - 1));
      if (bus.dl_wr & ~r_ldr_done & w_full) begin
        r_err_ovf <= 1'b1;
      end
    end
  end

  // Input edge registers and the pending end-of-download marker
  always_ff @(posedge clk21m or negedge rstn) begin
    if (!rstn) begin
      r_ack_q       <= 1'b0;
      r_dl_active_q <= 1'b0;
      r_pend_end    <= 1'b0;
    end else begin
      r_ack_q       <= bus.ldr_ack;
      r_dl_active_q <= bus.dl_active;
      if (w_dl_fall) begin
        r_pend_end <= 1'b1;
      end
    end
  end

  // Loader request/acknowledge FSM with ack timeout and write counter
  always_ff @(posedge clk21m or negedge rstn) begin
    if (!rstn) begin
      // Starting in REL means an ack already high at reset release must
      // fall before anything is issued, so it cannot count as a rise.
      r_state       <= ST_REL;
      r_ldr_wr      <= 1'b0;
      r_ldr_adr     <= '0;
      r_ldr_wdat    <= '0;
      r_tcnt        <= '0;
      r_byte_count  <= '0;
      r_err_timeout <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_issue) begin
            r_ldr_adr  <= w_head[ENT_W-1:8];
            r_ldr_wdat <= w_head[7:0];
            r_ldr_wr   <= 1'b1;
            r_tcnt     <= '0;
            r_state    <= ST_REQ;
          end
        end
        ST_REQ: begin
          // Ack is checked first so it wins over a same-cycle timeout
          if (w_ack_rise) begin
            r_ldr_wr <= 1'b0;
            if (r_byte_count != '1) begin
              r_byte_count <= r_byte_count + (ADDR_W + 1)'(1);
            end
            r_state <= ST_REL;
          end else if (w_tmo_hit) begin
            r_ldr_wr      <= 1'b0;
            r_err_timeout <= 1'b1;
            r_state       <= ST_REL;
          end else begin
            r_tcnt <= r_tcnt + TMO_W'(1);
          end
        end
        ST_REL: begin
          // Enforce an ack-low gap between consecutive requests
          if (!bus.ldr_ack) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Sticky completion flag and loader output-enable
  always_ff @(posedge clk21m or negedge rstn) begin
    if (!rstn) begin
      r_ldr_done <= 1'b0;
      r_ldr_oe   <= 1'b0;
    end else begin
      if (r_pend_end & w_fifo_empty & ~w_push & (r_state == ST_IDLE)) begin
        r_ldr_done <= 1'b1;
      end
      r_ldr_oe <= ~r_ldr_done &
                  (bus.dl_active | ~w_fifo_empty | (r_state != ST_IDLE));
    end
  end

  assign bus.dl_wait     = r_dl_wait;
  assign bus.ldr_adr     = r_ldr_adr;
  assign bus.ldr_wdat    = r_ldr_wdat;
  assign bus.ldr_wr      = r_ldr_wr;
  assign bus.ldr_oe      = r_ldr_oe;
  assign bus.ldr_done    = r_ldr_done;
  assign bus.byte_count  = r_byte_count;
  assign bus.err_ovf     = r_err_ovf;
  assign bus.err_timeout = r_err_timeout;

endmodule

// File: tb/tb_ioctl_loader_bridge.sv
// Self-checking bench for ioctl_loader_bridge: a scoreboard queue holds the
// {addr,data} entries expected on the loader port, popped on each new request.
module tb_ioctl_loader_bridge;

  localparam int AW = 19;
  typedef logic [AW+7:0] sb_t;

  logic clk21m;
  logic rstn;

  ioctl_loader_bridge_if #(.ADDR_W(AW)) bus ();

  ioctl_loader_bridge #(
    .ADDR_W      (AW),
    .DEPTH_LOG2  (2),
    .ACK_TIMEOUT (4095)
  ) dut (
    .clk21m (clk21m),
    .rstn   (rstn),
    .bus    (bus)
  );

  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_issue  = 0;
  sb_t  sb_q[$];

  logic man_ack;
  logic auto_ack;
  logic ack_auto_r;
  int   ack_delay;
  logic prev_wr;
  int   dcnt;

  assign bus.ldr_ack = auto_ack ? ack_auto_r : man_ack;

  initial begin
    clk21m = 1'b0;
    forever #5 clk21m = ~clk21m;
  end

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk21m);
    #1;
  endtask

  task automatic push(input logic [AW-1:0] a, input logic [7:0] d, input bit accept);
    bus.dl_wr   = 1'b1;
    bus.dl_addr = a;
    bus.dl_data = d;
    if (accept) sb_q.push_back({a, d});
    tick();
    bus.dl_wr = 1'b0;
  endtask

  task automatic wait_wr(input logic level, input int budget, input string tag);
    int n = 0;
    while (bus.ldr_wr !== level && n < budget) begin
      tick();
      n++;
    end
    check(tag, bus.ldr_wr, level);
  endtask

  task automatic wait_bc(input logic [AW:0] target, input int budget, input string tag);
    int n = 0;
    while (bus.byte_count !== target && n < budget) begin
      tick();
      n++;
    end
    check(tag, bus.byte_count, target);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wr"},    bus.ldr_wr,      0);
    check({tag, "_adr"},   bus.ldr_adr,     0);
    check({tag, "_wdat"},  bus.ldr_wdat,    0);
    check({tag, "_oe"},    bus.ldr_oe,      0);
    check({tag, "_done"},  bus.ldr_done,    0);
    check({tag, "_wait"},  bus.dl_wait,     0);
    check({tag, "_bc"},    bus.byte_count,  0);
    check({tag, "_ovf"},   bus.err_ovf,     0);
    check({tag, "_tmo"},   bus.err_timeout, 0);
  endtask

  // Loader-side responder: scoreboards each new request, optionally auto-acks
  initial begin
    prev_wr    = 1'b0;
    dcnt       = 0;
    ack_auto_r = 1'b0;
    forever begin
      @(negedge clk21m);
      if (bus.ldr_wr === 1'b1 && prev_wr !== 1'b1) begin
        sb_t e;
        check("sb_nonempty", 32'(sb_q.size() != 0), 1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          check("issue_adr",  32'(bus.ldr_adr),  32'(e[AW+7:8]));
          check("issue_wdat", 32'(bus.ldr_wdat), 32'(e[7:0]));
        end
        n_issue++;
      end
      prev_wr = bus.ldr_wr;
      if (!auto_ack) begin
        ack_auto_r = 1'b0;
        dcnt       = 0;
      end else if (bus.ldr_wr && !ack_auto_r) begin
        if (dcnt >= ack_delay) ack_auto_r = 1'b1;
        else dcnt++;
      end else if (!bus.ldr_wr && ack_auto_r) begin
        ack_auto_r = 1'b0;
        dcnt       = 0;
      end
    end
  end

  initial begin : main
    logic [AW:0] exp_bc;
    int          base;
    int          hi;
    logic        seen;

    rstn          = 1'b0;
    bus.dl_active = 1'b0;
    bus.dl_wr     = 1'b0;
    bus.dl_addr   = '0;
    bus.dl_data   = '0;
    man_ack       = 1'b0;
    auto_ack      = 1'b0;
    ack_delay     = 2;
    exp_bc        = '0;

    // Reset state
    repeat (3) tick();
    check_reset_outputs("rst");
    #2 rstn = 1'b1;
    repeat (3) tick();

    // Single byte: dl_wr in cycle n -> ldr_wr in n+2, ack in n+5 -> drop in n+6
    bus.dl_active = 1'b1;
    repeat (2) tick();
    push(19'h00010, 8'hA5, 1'b1);
    check("t1_wr_n1", bus.ldr_wr, 0);
    tick();
    check("t1_wr_n2",   bus.ldr_wr,   1);
    check("t1_adr",     bus.ldr_adr,  32'h10);
    check("t1_wdat",    bus.ldr_wdat, 32'hA5);
    check("t1_oe",      bus.ldr_oe,   1);
    repeat (3) tick();
    man_ack = 1'b1;
    check("t1_wr_hold", bus.ldr_wr, 1);
    tick();
    exp_bc = exp_bc + 1;
    check("t1_wr_drop", bus.ldr_wr, 0);
    check("t1_bc",      bus.byte_count, exp_bc);
    check("t1_wait",    bus.dl_wait, 0);
    man_ack = 1'b0;
    repeat (3) tick();

    // Back-pressure: 8 back-to-back writes with ack held low
    base = n_issue;
    for (int i = 0; i < 8; i++) begin
      push(19'(32'h100 + i), 8'(32'h10 + i), i < 4);
      if (i == 1) check("t2_wait_after2", bus.dl_wait, 0);
      if (i == 2) check("t2_wait_after3", bus.dl_wait, 1);
      if (i == 3) check("t2_ovf_after4",  bus.err_ovf, 0);
      if (i == 4) check("t2_ovf_after5",  bus.err_ovf, 1);
    end
    repeat (20) tick();
    check("t2_bc_stalled", bus.byte_count, exp_bc);
    auto_ack  = 1'b1;
    ack_delay = 2;
    wait_bc(exp_bc + 4, 200, "t2_drain_bc");
    exp_bc = exp_bc + 4;
    repeat (4) tick();
    check("t2_issues",   n_issue - base, 4);
    check("t2_sb_empty", sb_q.size(), 0);
    check("t2_wait_end", bus.dl_wait, 0);
    auto_ack = 1'b0;
    repeat (2) tick();

    // Ack held high across two requests
    push(19'h00080, 8'h11, 1'b1);
    push(19'h00081, 8'h22, 1'b1);
    wait_wr(1'b1, 10, "t4_req1");
    man_ack = 1'b1;
    tick();
    exp_bc = exp_bc + 1;
    check("t4_bc1", bus.byte_count, exp_bc);
    seen = 1'b0;
    repeat (8) begin
      tick();
      seen = seen | bus.ldr_wr;
    end
    check("t4_no_issue_ack_high", seen, 0);
    check("t4_bc_held",           bus.byte_count, exp_bc);
    man_ack = 1'b0;
    wait_wr(1'b1, 10, "t4_req2");
    man_ack = 1'b1;
    tick();
    exp_bc = exp_bc + 1;
    check("t4_bc2", bus.byte_count, exp_bc);
    man_ack = 1'b0;
    repeat (3) tick();

    // Ack timeout: no ack, entry abandoned, next entry still issued
    push(19'h00500, 8'h5A, 1'b1);
    push(19'h00501, 8'h5B, 1'b1);
    wait_wr(1'b1, 10, "t5_req");
    hi = 1;
    while (bus.ldr_wr && hi < 5000) begin
      tick();
      if (bus.ldr_wr) hi++;
      if (hi == 4000) check("t5_tmo_early", bus.err_timeout, 0);
    end
    check($sformatf("t5_req_cycles_%0d", hi), 32'(hi >= 4095 && hi <= 4097), 1);
    check("t5_wr_drop", bus.ldr_wr,      0);
    check("t5_tmo",     bus.err_timeout, 1);
    check("t5_bc_same", bus.byte_count,  exp_bc);
    wait_wr(1'b1, 10, "t5_next_issue");
    man_ack = 1'b1;
    tick();
    exp_bc = exp_bc + 1;
    check("t5_bc_next", bus.byte_count, exp_bc);
    man_ack = 1'b0;
    repeat (3) tick();

    // Completion ordering: dl_active falls with entries still queued
    auto_ack  = 1'b1;
    ack_delay = 3;
    for (int i = 0; i < 3; i++) push(19'(32'h200 + i), 8'(32'hC0 + i), 1'b1);
    bus.dl_active = 1'b0;
    check("t6_oe_busy", bus.ldr_oe, 1);
    hi = 0;
    while (!bus.ldr_done && hi < 300) begin
      tick();
      hi++;
    end
    check("t6_done",         bus.ldr_done,   1);
    check("t6_bc_at_done",   bus.byte_count, exp_bc + 3);
    check("t6_wr_at_done",   bus.ldr_wr,     0);
    exp_bc = exp_bc + 3;
    tick();
    check("t6_oe_after",     bus.ldr_oe,     0);
    auto_ack = 1'b0;

    // ldr_done is sticky: new download rise and writes are ignored
    bus.dl_active = 1'b1;
    repeat (2) tick();
    base = n_issue;
    push(19'h00300, 8'h77, 1'b0);
    repeat (6) tick();
    check("t7_done_sticky", bus.ldr_done,   1);
    check("t7_no_issue",    n_issue - base, 0);
    check("t7_bc_same",     bus.byte_count, exp_bc);
    check("t7_oe",          bus.ldr_oe,     0);

    // Reset mid-transfer with ack high at release
    #2 rstn = 1'b0;
    tick();
    #2 rstn = 1'b1;
    repeat (3) tick();
    sb_q.delete();
    exp_bc = '0;
    check("t8_done_cleared", bus.ldr_done, 0);
    for (int i = 0; i < 3; i++) push(19'(32'h400 + i), 8'(32'h40 + i), 1'b1);
    wait_wr(1'b1, 10, "t8_req");
    check("t8_wait_full", bus.dl_wait, 1);
    #2 rstn = 1'b0;
    #1;
    check_reset_outputs("t8_async");
    man_ack       = 1'b1;
    sb_q.delete();
    bus.dl_active = 1'b0;
    repeat (2) tick();
    #2 rstn = 1'b1;
    repeat (10) tick();
    check("t8_bc_no_spurious", bus.byte_count, 0);
    check("t8_done",           bus.ldr_done,   0);
    check("t8_wr",             bus.ldr_wr,     0);
    man_ack = 1'b0;
    repeat (2) tick();

    // Restart after reset, then completion with an already-empty FIFO
    bus.dl_active = 1'b1;
    auto_ack      = 1'b1;
    ack_delay     = 1;
    repeat (3) tick();
    push(19'h7FFFF, 8'hFF, 1'b1);
    wait_bc(1, 50, "t9_restart_bc");
    repeat (4) tick();
    auto_ack = 1'b0;
    check("t9_sb_empty", sb_q.size(), 0);
    bus.dl_active = 1'b0;
    check("t9_done_f0", bus.ldr_done, 0);
    tick();
    check("t9_done_f1", bus.ldr_done, 0);
    tick();
    check("t9_done_f2", bus.ldr_done, 1);
    repeat (2) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
